// File: rtl/ps2_pkg.sv
// Shared PS/2 types and helpers for the host transmitter and keyboard receiver.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        ERROR
    } ps2_tx_state_t;

    // Odd parity bit: data plus this bit always carries an odd number of ones.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Reset to 1: an idle PS/2 bus floats high, so no false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter; drives the bus only via pull-low enables.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus released, ready for a command byte
// INHIBIT   | clock held low to stop the device transmitting
// REQ       | clock and data both low for one cycle (request to send)
// SEND      | clock released; one frame bit presented per device fall
// ACK       | stop bit out, waiting for the device to pull data low
// WAIT_IDLE | ack seen, waiting for both lines high, then done pulse
// ERROR     | lines released, err pulse for one cycle
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tx_valid,
    input  logic [PS2_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     ps2_clk_in,
    input  logic                     ps2_data_in,
    output logic                     ps2_clk_oe,
    output logic                     ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = '1;
    localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 2);

    ps2_tx_state_t               state;
    logic [PS2_FRAME_BITS-2:0]   shift;
    logic [3:0]                  bit_cnt;
    logic [INH_W-1:0]            inh_cnt;
    logic [TO_W-1:0]             to_cnt;

    logic clk_level;
    logic clk_fall;
    logic data_meta;
    logic data_sync;
    logic timer_on;
    logic to_expire;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign timer_on = (state == REQ) || (state == SEND) ||
                      (state == ACK) || (state == WAIT_IDLE);

    // A fall in the expiry cycle means the device made it in time.
    assign to_expire = timer_on && !clk_fall && (to_cnt == TO_LAST) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (timer_on) begin
                if (clk_fall) begin
                    to_cnt <= '0;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            if (to_expire) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                err         <= 1'b1;
                state       <= ERROR;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            shift      <= {1'b1, odd_parity(tx_data), tx_data};
                            bit_cnt    <= '0;
                            inh_cnt    <= '0;
                            to_cnt     <= '0;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            ps2_data_oe <= 1'b1;
                            to_cnt      <= '0;
                            state       <= REQ;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end

                    REQ: begin
                        ps2_clk_oe <= 1'b0;
                        state      <= SEND;
                    end

                    SEND: begin
                        if (clk_fall) begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= {1'b0, shift[PS2_FRAME_BITS-2:1]};
                            if (bit_cnt != 4'hF) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                            if (bit_cnt == LAST_BIT) begin
                                state <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state <= WAIT_IDLE;
                            end else begin
                                err   <= 1'b1;
                                state <= ERROR;
                            end
                        end
                    end

                    // done is held in this state for its pulse so the next
                    // accept lands on the following cycle.
                    WAIT_IDLE: begin
                        if (done) begin
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else if (clk_level && data_sync) begin
                            done <= 1'b1;
                        end
                    end

                    ERROR: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end

                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock/data pair. It is the opposite direction to the existing keyboard scan-code receiver. The block runs on the system clock, oversamples the device-generated PS/2 clock, and drives both lines only through active-high pull-low enables.

Parameters:
INHIBIT_CYCLES, 5000, system-clock cycles the PS/2 clock is held low before the request (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum system-clock cycles allowed between consecutive device clock falling edges, and from request to first edge (15 ms at 50 MHz).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  request to send tx_data
tx_data  input  8  command byte, sent LSB first
tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high
busy  output  1  high in every state except IDLE; the receiver must ignore the bus while high
done  output  1  one-cycle pulse when the device ack is received and the bus has returned to idle
err  output  1  one-cycle pulse on timeout or missing ack
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  output  1  1 = pull PS/2 clock low
ps2_data_oe  output  1  1 = pull PS/2 data low

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE
  - ps2_clk_oe=0, ps2_data_oe=0
  - done=0, err=0
  - tx_ready=1, busy=0
  - shift register and counters cleared
- Reset mid-frame releases both lines immediately (asynchronously). There is no done or err pulse for the aborted frame.
- Input sampling:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - fall = previous synced clock & ~current synced clock.
  - Edge-to-action latency is 3 system clocks, which is negligible against the 10-16.7 kHz PS/2 clock.
- Frame: shift register = {stop=1, parity=~^tx_data, tx_data}, 10 bits, loaded on acceptance. Parity is odd: total number of ones over data plus parity is odd.
- States:
  - IDLE: both oe=0. On accept, load the frame, clear the counter, go to INHIBIT. Edges on ps2_clk_in are ignored in IDLE.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: one cycle with clk_oe=1 and data_oe=1 (start bit 0), then clk_oe=0 and go to SEND. The timeout counter starts here.
  - SEND:
    - On each fall, set data_oe = ~shift[0], shift right, and increment bit_cnt.
    - Falls 1-8 present data bits 0-7, fall 9 presents parity, fall 10 presents stop (data_oe=0).
    - After fall 10, go to ACK.
  - ACK: on the next fall (11th), sample synced data. 0 goes to WAIT_IDLE; 1 goes to ERROR.
  - WAIT_IDLE: wait until synced clock=1 and synced data=1, then pulse done and return to IDLE.
  - ERROR: oe both 0, pulse err, return to IDLE (one cycle).
- Timeout counter:
  - Clears on every fall and runs in REQ, SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES goes to ERROR from any of those states.
- tx_valid while busy is ignored; the held byte is not queued.
- done and err are never high together.
- Back-to-back operation: a new byte can be accepted the cycle after done or err (IDLE).
- bit_cnt is 4 bits. Counters are sized by $clog2 of their parameter and saturate, never wrap.

Decomposition:
- Package ps2_pkg:
  - host transmitter state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, ERROR)
  - PS2_DATA_BITS=8 and PS2_FRAME_BITS=11
  - function odd_parity(byte)
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detector, outputs the synced level and a fall pulse. It is instantiated for the clock line and reusable by the receiver.

Test Plan:
Bench parameters are INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=200, with a device BFM that clocks at 1/40 of clk and acks by default.
1. tx_data=0xED -> clk_oe low for 8 cycles; data bits seen on device rising edges: 0(start),1,0,1,1,0,1,1,1, parity 1, stop 1; BFM acks -> single done pulse, err=0, tx_ready=1 afterwards.
2. tx_data=0x01 -> parity bit 0; tx_data=0x00 -> parity bit 1; BFM parity checker passes both.
3. BFM leaves data high on the 11th clock (no ack) -> err pulse one cycle after that fall, done stays 0, both oe=0.
4. BFM never clocks after the request -> err exactly TIMEOUT_CYCLES after REQ, lines released; BFM stops clocking after bit 4 -> err 200 cycles after the last fall.
5. rst_n asserted after bit 3 -> ps2_clk_oe=ps2_data_oe=0 immediately; after release tx_ready=1, no done or err pulse.
6. tx_valid held high with 0xF4 then 0xAA changed mid-frame -> only 0xF4 sent; second accept occurs the cycle after done; the two frames are sent back-to-back correctly.
